circular_buffer: RTL and testbench
==================================

CIRCULAR_BUFFER -- requirements
Module: circular_buffer

Interface
REQ-001 SHALL provide parameter BUFFER_SIZE, default 24000: number of 16-bit storage entries.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 15: pointer width, with 2^ADDR_WIDTH >= BUFFER_SIZE.
REQ-003 SHALL provide parameter PRE_TRIGGER_SAMPLES, default 3200: rewind distance in samples, with 0 < PRE_TRIGGER_SAMPLES < BUFFER_SIZE.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 data_in  input  16  sample to store.
REQ-008 sample_valid  input  1  write strobe, one sample per high cycle.
REQ-009 rd_en  input  1  read strobe, one sample per high cycle.
REQ-010 pre_trig_rewind  input  1  repositions the read pointer behind the write pointer.
REQ-011 data_out  output  16  registered read data.
REQ-012 data_valid  output  1  one-cycle pulse qualifying data_out.
REQ-013 buffer_full  output  1  indicates the buffer has been completely written at least once.

Function
REQ-014 SHALL hold mem[0..BUFFER_SIZE-1] of 16 bits plus wr_ptr and rd_ptr, each ADDR_WIDTH bits wide.
REQ-015 On a clk edge with sample_valid=1: mem[wr_ptr] <= data_in, and wr_ptr advances; at BUFFER_SIZE-1 it wraps to 0. The oldest data is overwritten and there is no overflow stall.
REQ-016 On a clk edge with rd_en=1 and no rewind: data_out <= mem[rd_ptr], data_valid <= 1, and rd_ptr advances with the same wrap rule.
REQ-017 Read latency SHALL be one cycle: data_valid and data_out are updated at the same edge that samples rd_en.
REQ-018 data_valid SHALL be 0 on every edge where no read is performed.
REQ-019 data_out SHALL hold its last read value when no read is performed.
REQ-020 On a clk edge with pre_trig_rewind=1: rd_ptr <= (wr_ptr - PRE_TRIGGER_SAMPLES) mod BUFFER_SIZE.
  - If wr_ptr >= PRE_TRIGGER_SAMPLES: rd_ptr = wr_ptr - PRE_TRIGGER_SAMPLES.
  - Otherwise: rd_ptr = wr_ptr + BUFFER_SIZE - PRE_TRIGGER_SAMPLES.
  - No address outside 0..BUFFER_SIZE-1 SHALL ever be produced.
REQ-021 The rewind calculation SHALL use the wr_ptr value before any write in the same cycle.
REQ-022 If pre_trig_rewind and rd_en are both high in the same cycle, the rewind wins: no read occurs and data_valid=0.
REQ-023 A write and a read may occur in the same cycle.
  - If both target the same address, the read SHALL return the old memory contents (read-before-write).
REQ-024 buffer_full SHALL set to 1 on the write that wraps wr_ptr from BUFFER_SIZE-1 to 0, and SHALL remain 1 until reset.
REQ-025 Memory SHALL be inferable as a simple dual-port block RAM with a synchronous read port.

Reset
REQ-026 While rst_n=0, regardless of the clock: wr_ptr=0, rd_ptr=0, data_out=0, data_valid=0, buffer_full=0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 A reset asserted mid-operation SHALL abort any read in progress; the first write after reset goes to address 0.

Configuration
REQ-029 Macro CIRCULAR_BUFFER_EMPTY_GUARD_EN SHALL control the empty-read guard.
  - Defined: a read is suppressed when rd_ptr==wr_ptr and buffer_full==0. rd_ptr does not move, data_valid stays 0, and data_out holds.
  - Undefined: reads always proceed per REQ-016, with no empty check.

Verification
REQ-030 Reset; write 0x0001..0x000A; perform 10 reads -> data_out 0x0001..0x000A in order, each with a one-cycle data_valid pulse.
REQ-031 Reset; write 24000 samples -> buffer_full=1 after the last write; one further write of 0xBEEF lands at address 0 with no X on data_out.
REQ-032 Reset; write 4000 samples of value 0x1000+i; pulse pre_trig_rewind; read 4 -> 0x1320, 0x1321, 0x1322, 0x1323.
REQ-033 Reset; write 24000 samples of value i, then 100 samples of 0xA000+i; pulse pre_trig_rewind; read 2 -> 20900, 20901.
REQ-034 Reset; write 0xCAFE, 0xDEAD.
  - data_valid=0 before any rd_en.
  - One rd_en -> data_valid=1 with data_out=0xCAFE one cycle later.
  - data_valid=0 on the following cycle.
REQ-035 Assert rd_en and pre_trig_rewind together -> data_valid=0 and the rewind is applied; with CIRCULAR_BUFFER_EMPTY_GUARD_EN defined, rd_en straight after reset -> data_valid stays 0.

Source files
------------

// File: rtl/circular_buffer.sv
// circular_buffer: 16-bit sample ring buffer with a write pointer, a read
// pointer, a one-cycle registered read port and a pre-trigger rewind that
// places the read pointer a fixed distance behind the write pointer.
// Optional feature macro: CIRCULAR_BUFFER_EMPTY_GUARD_EN (suppresses reads
// while the buffer is empty, i.e. rd_ptr == wr_ptr before the first wrap).
module circular_buffer #(
   parameter int BUFFER_SIZE         = 24000,
   parameter int ADDR_WIDTH          = 15,
   parameter int PRE_TRIGGER_SAMPLES = 3200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data_in,
   input  logic        sample_valid,
   input  logic        rd_en,
   input  logic        pre_trig_rewind,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        buffer_full
);

   localparam logic [ADDR_WIDTH-1:0] LP_LAST   = ADDR_WIDTH'(BUFFER_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] LP_PRE    = ADDR_WIDTH'(PRE_TRIGGER_SAMPLES);
   localparam logic [ADDR_WIDTH-1:0] LP_REWRAP = ADDR_WIDTH'(BUFFER_SIZE - PRE_TRIGGER_SAMPLES);
   localparam logic [ADDR_WIDTH-1:0] LP_ONE    = ADDR_WIDTH'(1);

   // Storage has no reset so it maps onto block RAM.
   logic [15:0]           r_mem [0:BUFFER_SIZE-1];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [15:0]           r_data_out;
   logic                  r_data_valid;
   logic                  r_buffer_full;

   logic [ADDR_WIDTH-1:0] w_wr_ptr_inc;
   logic [ADDR_WIDTH-1:0] w_rd_ptr_inc;
   logic [ADDR_WIDTH-1:0] w_rewind_ptr;
   logic                  w_empty;
   logic                  w_read_en;

   // Pointer increment with wrap, rewind target and read qualification.
   always_comb begin
      w_wr_ptr_inc = (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + LP_ONE;
      w_rd_ptr_inc = (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + LP_ONE;
      // Both branches stay inside 0..BUFFER_SIZE-1; uses the pre-write wr_ptr.
      w_rewind_ptr = (r_wr_ptr >= LP_PRE) ? (r_wr_ptr - LP_PRE)
                                          : (r_wr_ptr + LP_REWRAP);
`ifdef CIRCULAR_BUFFER_EMPTY_GUARD_EN
      w_empty = (r_rd_ptr == r_wr_ptr) && !r_buffer_full;
`else
      w_empty = 1'b0;
`endif
      // A rewind in the same cycle takes priority over a read.
      w_read_en = rd_en && !pre_trig_rewind && !w_empty;
   end

   // Memory write port; overwrites the oldest entry without stalling.
   always_ff @(posedge clk) begin
      if (sample_valid) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Registered read port; a same-address write returns the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out <= '0;
      end else if (w_read_en) begin
         r_data_out <= r_mem[r_rd_ptr];
      end
   end

   // Pointers, read strobe and the sticky full flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_data_valid  <= 1'b0;
         r_buffer_full <= 1'b0;
      end else begin
         r_data_valid <= w_read_en;
         if (sample_valid) begin
            r_wr_ptr <= w_wr_ptr_inc;
            if (r_wr_ptr == LP_LAST) begin
               r_buffer_full <= 1'b1;
            end
         end
         if (pre_trig_rewind) begin
            r_rd_ptr <= w_rewind_ptr;
         end else if (w_read_en) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
      end
   end

   assign data_out    = r_data_out;
   assign data_valid  = r_data_valid;
   assign buffer_full = r_buffer_full;

endmodule

// File: tb/tb_circular_buffer.sv
// tb_circular_buffer: directed scenarios plus randomized traffic for
// circular_buffer, checked against an array/modulo reference model.
module tb_circular_buffer;

   localparam int BS  = 24000;
   localparam int AW  = 15;
   localparam int PRE = 3200;

   logic        clk;
   logic        rst_n;
   logic [15:0] data_in;
   logic        sample_valid;
   logic        rd_en;
   logic        pre_trig_rewind;
   logic [15:0] data_out;
   logic        data_valid;
   logic        buffer_full;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int   m_mem [BS];
   bit   m_written [BS];
   int   m_wr, m_rd;
   bit   m_full;
   int   m_dout;
   bit   m_dout_known;
   bit   m_valid;

   circular_buffer #(
      .BUFFER_SIZE(BS), .ADDR_WIDTH(AW), .PRE_TRIGGER_SAMPLES(PRE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .sample_valid(sample_valid),
      .rd_en(rd_en), .pre_trig_rewind(pre_trig_rewind), .data_out(data_out),
      .data_valid(data_valid), .buffer_full(buffer_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_wr = 0; m_rd = 0; m_full = 0;
      m_dout = 0; m_dout_known = 1; m_valid = 0;
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_edge(input bit v, input int d, input bit rd, input bit rew);
      bit empty;
      bit do_rd;
`ifdef CIRCULAR_BUFFER_EMPTY_GUARD_EN
      empty = (m_rd == m_wr) && !m_full;
`else
      empty = 0;
`endif
      do_rd = rd && !rew && !empty;
      m_valid = do_rd;
      if (do_rd) begin
         m_dout       = m_mem[m_rd];
         m_dout_known = m_written[m_rd];
         m_rd         = (m_rd + 1) % BS;
      end
      if (rew) m_rd = (m_wr + BS - PRE) % BS;
      if (v) begin
         m_mem[m_wr]     = d;
         m_written[m_wr] = 1;
         if (m_wr == BS - 1) m_full = 1;
         m_wr = (m_wr + 1) % BS;
      end
   endtask

   // Drive one cycle, advance the model, then compare outputs after the edge.
   task automatic step(input bit v, input logic [15:0] d, input bit rd, input bit rew);
      @(negedge clk);
      sample_valid = v; data_in = d; rd_en = rd; pre_trig_rewind = rew;
      @(posedge clk);
      model_edge(v, int'(d), rd, rew);
      #1;
      chk("valid", {31'd0, data_valid}, {31'd0, m_valid});
      chk("full", {31'd0, buffer_full}, {31'd0, m_full});
      if (m_dout_known) chk("dout", {16'd0, data_out}, m_dout[31:0] & 32'hFFFF);
   endtask

   // Reset asserted between edges; an in-flight rd_en must be ignored.
   task automatic do_reset(input bit rd_during);
      @(negedge clk);
      rd_en = rd_during; sample_valid = 0; pre_trig_rewind = 0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_dout", {16'd0, data_out}, 32'd0);
      chk("rst_valid", {31'd0, data_valid}, 32'd0);
      chk("rst_full", {31'd0, buffer_full}, 32'd0);
      @(posedge clk); #1;
      chk("rst_hold_valid", {31'd0, data_valid}, 32'd0);
      @(negedge clk);
      rd_en = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; data_in = '0; sample_valid = 0; rd_en = 0; pre_trig_rewind = 0;
      for (int i = 0; i < BS; i++) begin m_mem[i] = 0; m_written[i] = 0; end
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Sequential write then read of ten samples.
      do_reset(0);
      for (int i = 1; i <= 10; i++) step(1, 16'(i), 0, 0);
      for (int i = 1; i <= 10; i++) begin
         step(0, 16'h0, 1, 0);
         $display("read %0d: data_out=%04h valid=%0b", i, data_out, data_valid);
         chk("seq_dout", {16'd0, data_out}, 32'(i));
         chk("seq_valid", {31'd0, data_valid}, 32'd1);
      end

      // Single-read pulse shape.
      do_reset(0);
      step(1, 16'hCAFE, 0, 0);
      step(1, 16'hDEAD, 0, 0);
      chk("pulse_pre", {31'd0, data_valid}, 32'd0);
      step(0, 16'h0, 1, 0);
      $display("read: data_out=%04h valid=%0b", data_out, data_valid);
      chk("pulse_dout", {16'd0, data_out}, 32'hCAFE);
      chk("pulse_valid", {31'd0, data_valid}, 32'd1);
      step(0, 16'h0, 0, 0);
      chk("pulse_after", {31'd0, data_valid}, 32'd0);
      chk("pulse_holddout", {16'd0, data_out}, 32'hCAFE);

      // Rewind without wrap.
      do_reset(0);
      for (int i = 0; i < 4000; i++) step(1, 16'(16'h1000 + i), 0, 0);
      step(0, 16'h0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 16'h0, 1, 0);
         $display("rewind read %0d: data_out=%04h", i, data_out);
         chk("rew_dout", {16'd0, data_out}, 32'(16'h1320 + i));
      end

      // Full fill, wrap write and sticky full.
      do_reset(0);
      for (int i = 0; i < BS; i++) begin
         step(1, 16'(i), 0, 0);
         if (i == BS - 2) chk("full_early", {31'd0, buffer_full}, 32'd0);
      end
      chk("full_set", {31'd0, buffer_full}, 32'd1);
      step(1, 16'hBEEF, 0, 0);
      step(0, 16'h0, 1, 0);
      $display("wrap read: data_out=%04h", data_out);
      chk("wrap_dout", {16'd0, data_out}, 32'hBEEF);
      chk("wrap_nox", {31'd0, $isunknown(data_out)}, 32'd0);
      chk("full_sticky", {31'd0, buffer_full}, 32'd1);

      // Rewind across the wrap point.
      do_reset(0);
      for (int i = 0; i < BS; i++) step(1, 16'(i), 0, 0);
      for (int i = 0; i < 100; i++) step(1, 16'(16'hA000 + i), 0, 0);
      step(0, 16'h0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         step(0, 16'h0, 1, 0);
         $display("wrap rewind read %0d: data_out=%0d", i, data_out);
         chk("wrew_dout", {16'd0, data_out}, 32'(20900 + i));
      end

      // Read and rewind together: rewind wins, then read lands on the rewind target.
      step(1, 16'h5555, 1, 1);
      chk("rdrew_valid", {31'd0, data_valid}, 32'd0);
      step(0, 16'h0, 1, 0);
      chk("rdrew_dout", {16'd0, data_out}, 32'(100 + BS - PRE));

      // Same-address write and read: old contents are returned.
      for (int i = 0; i < 200; i++) step(0, 16'h0, 1, 0);
      while (m_rd != m_wr) step(0, 16'h0, 1, 0);
      step(1, 16'h7777, 1, 0);

      // Randomized traffic on a fully written buffer.
      for (int i = 0; i < 3000; i++)
         step(1'($urandom % 2), 16'($urandom), 1'($urandom % 2), ($urandom % 64) == 0);

      // Reset in the middle of a read, then first write goes to address 0.
      step(1, 16'h1234, 1, 0);
      do_reset(1);
      step(1, 16'h4321, 0, 0);
      step(1, 16'h9999, 0, 0);
      step(0, 16'h0, 1, 0);
      chk("post_rst_addr0", {16'd0, data_out}, 32'h4321);

`ifdef CIRCULAR_BUFFER_EMPTY_GUARD_EN
      // Empty guard: read straight after reset is suppressed.
      do_reset(0);
      step(0, 16'h0, 1, 0);
      chk("guard_valid", {31'd0, data_valid}, 32'd0);
      chk("guard_dout", {16'd0, data_out}, 32'd0);
      step(1, 16'h0ABC, 0, 0);
      step(0, 16'h0, 1, 0);
      chk("guard_after", {16'd0, data_out}, 32'h0ABC);
`endif

      step(0, 16'h0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
